mem_dados_resp: RTL and testbench
=================================

Name: mem_dados_resp

Overview:
- Responder (memory side) of the processor data-memory interface. The datapath issues load/store requests; this block answers them.
- Word-organised RAM with byte/half/word access selected by funct3 and little-endian lane steering.
- Programmable wait states, so the datapath can move to a multi-cycle/handshaked memory bus.
- Sits between the CamDado data port (address = ULA result, write data = rs2) and the RAM array.

Parameters:
- BASE_ADDR, 32'h10010000, byte address mapped to RAM word 0.
- DEPTH_WORDS, 1024, RAM size in 32-bit words; must be a power of 2.
- LATENCY, 2, wait cycles between request accept and the response cycle; legal range 0..15.

Ports:
- iCLK  in  1  clock, rising edge.
- iRST  in  1  asynchronous, active-high reset.
- iReq  in  1  request valid; held high by the initiator until oReady.
- iWe  in  1  1 = store, 0 = load.
- iAddr  in  32  byte address.
- iWData  in  32  store data; the low byte/half is used for sb/sh.
- iFunct3  in  3  access size/sign, per RV32I load/store funct3.
- oReady  out  1  one-cycle response strobe.
- oRData  out  32  load result, valid while oReady=1.
- oErr  out  1  request rejected, valid while oReady=1.
- oBusy  out  1  high in the WAIT and RESP states.

Behaviour:
- Reset (asynchronous): state=IDLE, wait counter=0, oReady=0, oRData=0, oErr=0, oBusy=0. RAM contents are not cleared.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If iReq=1, latch iWe, iAddr, iWData and iFunct3, and compute the error flag.
  - Go to WAIT with counter=LATENCY-1, or go directly to RESP if LATENCY=0.
- WAIT:
  - Decrement the counter.
  - When the counter reaches 0, go to RESP on the next edge.
  - Accept-to-oReady latency is exactly LATENCY+1 cycles.
  - Input changes during WAIT are ignored; only the latched copy is used.
- Store commit: on the edge entering RESP, write the enabled byte lanes, but only if there is no error.
- RESP:
  - oReady=1 for exactly one cycle.
  - For a load, oRData = the extracted value (combinational read of the latched word).
  - For a store or an error, oRData=0. oErr reflects the latched error flag.
  - Always return to IDLE. iReq seen in RESP is not accepted.
  - Earliest next accept is the cycle after RESP, giving one idle bubble between transactions.
- Address decode:
  - offset = latched addr - BASE_ADDR.
  - Word index = offset[log2(DEPTH)+1:2].
  - Byte lane = offset[1:0].
- Loads:
  - 000 lb: byte at the lane, sign-extended.
  - 100 lbu: byte at the lane, zero-extended.
  - 001 lh: half at lane 0 or 2, sign-extended.
  - 101 lhu: half at lane 0 or 2, zero-extended.
  - 010 lw: full word.
- Stores:
  - 000 sb: byte enable = 1 << lane, data = replicated iWData[7:0].
  - 001 sh: enables 4'b0011 or 4'b1100, data = replicated iWData[15:0].
  - 010 sw: enables 4'b1111.
- oErr=1 for any of:
  - addr < BASE_ADDR, or addr >= BASE_ADDR + 4*DEPTH_WORDS (no wrap-around aliasing);
  - half access with addr[0]=1;
  - word access with addr[1:0]!=0;
  - load funct3 in {011, 110, 111};
  - store funct3 other than 000/001/010.
- On error: no RAM write, oRData=0.
- Reset mid-transaction (WAIT): the transaction is aborted, no write occurs, and oReady is never raised. A store already committed (RESP reached) stays in RAM.
- Back-to-back: the initiator holding iReq high through RESP gets its next transaction accepted in the following IDLE cycle.

Test Plan:
- Reset, then sw addr=0x10010000 data=0xDEADBEEF, then lw from the same address → oReady exactly 3 cycles after accept (LATENCY=2); oRData=0xDEADBEEF, oErr=0.
- Loads from 0x10010000, which holds 0xDEADBEEF:
  - lb at +3 → 0xFFFFFFDE; lbu at +3 → 0x000000DE.
  - lh at +0 → 0xFFFFBEEF; lhu at +2 → 0x0000DEAD.
- Partial stores: sb 0x11 at +1, then sh 0x2233 at +2, then lw → 0x223311EF.
- Errors, each giving oReady=1, oErr=1, oRData=0 and RAM unchanged:
  - lw at 0x10010002 (misaligned);
  - sw at 0x10011000 (out of range with DEPTH=1024);
  - lw at 0x1000FFFC (below base).
- Reset during WAIT: sw 0x12345678 to +8, assert iRST one cycle after accept → oReady never pulses. A following lw +8 returns the prior contents (0x00000000 if never written).
- LATENCY=0 build: lw accepted → oReady on the next cycle. With iReq held continuously, responses pulse every 2 cycles, and oBusy toggles accordingly.

Source files
------------

// File: rtl/mem_dados_resp.sv
// Data-memory responder: word-organised RAM behind a req/ready handshake with
// programmable wait states, RV32I byte/half/word lane steering and access checks.
//
// state | meaning
// IDLE  | waiting for iReq; request fields and error flag captured on accept
// WAIT  | counting down wait states, inputs ignored
// RESP  | one-cycle oReady strobe with load data / error flag
module mem_dados_resp #(
    parameter logic [31:0] BASE_ADDR   = 32'h10010000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 2
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iReq,
    input  logic        iWe,
    input  logic [31:0] iAddr,
    input  logic [31:0] iWData,
    input  logic [2:0]  iFunct3,
    output logic        oReady,
    output logic [31:0] oRData,
    output logic        oErr,
    output logic        oBusy
);

    localparam int          AW       = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN     = 32'(4 * DEPTH_WORDS);
    localparam logic [3:0]  CNT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [2:0]  f3_q;

    logic [31:0] ram [DEPTH_WORDS];

    logic        cur_we;
    logic [31:0] cur_addr;
    logic [31:0] cur_wdata;
    logic [2:0]  cur_f3;
    logic [31:0] offset;
    logic [AW-1:0] word_idx;
    logic [1:0]  lane;
    logic        in_range;
    logic        bad_access;
    logic        cur_err;
    logic [31:0] ram_word;
    logic [31:0] shifted;
    logic [31:0] load_val;
    logic [3:0]  byte_en;
    logic [31:0] store_data;
    logic        go_resp;
    logic        wr_en;

    // In IDLE the decode looks at the live inputs so a zero-latency build can
    // commit on the accept edge; afterwards only the latched copy is used.
    always_comb begin
        cur_we    = iWe;
        cur_addr  = iAddr;
        cur_wdata = iWData;
        cur_f3    = iFunct3;
        if (state != IDLE) begin
            cur_we    = we_q;
            cur_addr  = addr_q;
            cur_wdata = wdata_q;
            cur_f3    = f3_q;
        end
    end

    assign offset   = cur_addr - BASE_ADDR;
    assign word_idx = offset[AW+1:2];
    assign lane     = offset[1:0];

    // Range test on the unwrapped offset so addresses past the top never alias.
    assign in_range = (cur_addr >= BASE_ADDR) && (offset < SPAN);

    always_comb begin
        bad_access = 1'b1;
        case (cur_f3)
            3'b000:  bad_access = 1'b0;
            3'b001:  bad_access = offset[0];
            3'b010:  bad_access = |offset[1:0];
            3'b100:  bad_access = cur_we;
            3'b101:  bad_access = cur_we | offset[0];
            default: bad_access = 1'b1;
        endcase
    end

    assign cur_err = !in_range || bad_access;

    assign ram_word = ram[word_idx];
    assign shifted  = ram_word >> {lane, 3'b000};

    always_comb begin
        load_val = 32'd0;
        case (cur_f3)
            3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
            3'b100:  load_val = {24'd0, shifted[7:0]};
            3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
            3'b101:  load_val = {16'd0, shifted[15:0]};
            3'b010:  load_val = ram_word;
            default: load_val = 32'd0;
        endcase
    end

    always_comb begin
        byte_en    = 4'b0000;
        store_data = cur_wdata;
        case (cur_f3)
            3'b000: begin
                byte_en    = 4'b0001 << lane;
                store_data = {4{cur_wdata[7:0]}};
            end
            3'b001: begin
                byte_en    = lane[1] ? 4'b1100 : 4'b0011;
                store_data = {2{cur_wdata[15:0]}};
            end
            3'b010:  byte_en = 4'b1111;
            default: byte_en = 4'b0000;
        endcase
    end

    assign go_resp = ((state == IDLE) && iReq && (LATENCY == 0)) ||
                     ((state == WAIT) && (cnt == 4'd0));
    assign wr_en   = go_resp && cur_we && !cur_err && !iRST;

    // RAM is never reset; contents survive iRST.
    always_ff @(posedge iCLK) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    ram[word_idx][8*b +: 8] <= store_data[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            f3_q    <= 3'd0;
            oReady  <= 1'b0;
            oRData  <= 32'd0;
            oErr    <= 1'b0;
            oBusy   <= 1'b0;
        end else begin
            oReady <= 1'b0;
            oRData <= 32'd0;
            oErr   <= 1'b0;
            case (state)
                IDLE: begin
                    if (iReq) begin
                        we_q    <= iWe;
                        addr_q  <= iAddr;
                        wdata_q <= iWData;
                        f3_q    <= iFunct3;
                        cnt     <= CNT_INIT;
                        oBusy   <= 1'b1;
                        state   <= (LATENCY == 0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    oBusy <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    oBusy <= 1'b0;
                    state <= IDLE;
                end
            endcase
            if (go_resp) begin
                oReady <= 1'b1;
                oErr   <= cur_err;
                oRData <= (cur_we || cur_err) ? 32'd0 : load_val;
            end
        end
    end

endmodule

// File: tb/tb_mem_dados_resp.sv
// Directed bench for mem_dados_resp: a LATENCY=2 instance for functional checks
// and a LATENCY=0 instance for single-cycle and back-to-back timing.
module tb_mem_dados_resp;

    localparam logic [31:0] B = 32'h10010000;

    logic        clk = 1'b0;
    logic        rst;
    logic        req, we;
    logic [31:0] addr, wdata;
    logic [2:0]  f3;
    logic        ready, err, busy;
    logic [31:0] rdata;
    logic        req0, we0;
    logic [31:0] addr0, wdata0;
    logic [2:0]  f30;
    logic        ready0, err0, busy0;
    logic [31:0] rdata0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_dados_resp #(.BASE_ADDR(B), .DEPTH_WORDS(1024), .LATENCY(2)) dut (
        .iCLK(clk), .iRST(rst), .iReq(req), .iWe(we), .iAddr(addr),
        .iWData(wdata), .iFunct3(f3), .oReady(ready), .oRData(rdata),
        .oErr(err), .oBusy(busy)
    );

    mem_dados_resp #(.BASE_ADDR(B), .DEPTH_WORDS(1024), .LATENCY(0)) dut0 (
        .iCLK(clk), .iRST(rst), .iReq(req0), .iWe(we0), .iAddr(addr0),
        .iWData(wdata0), .iFunct3(f30), .oReady(ready0), .oRData(rdata0),
        .oErr(err0), .oBusy(busy0)
    );

    // Runs one transaction; lat = cycles from accept cycle to oReady (0 = timeout).
    task automatic txn(input bit sel0, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [2:0] f,
                       output logic [31:0] rd, output logic er,
                       output int lat, output int busy_n);
        lat = 0;
        busy_n = 0;
        rd = 32'hxxxxxxxx;
        er = 1'bx;
        if (sel0) begin
            req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; f30 = f;
        end else begin
            req = 1'b1; we = w; addr = a; wdata = d; f3 = f;
        end
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (sel0 ? busy0 : busy) busy_n++;
            if (sel0 ? ready0 : ready) begin
                lat = n;
                rd  = sel0 ? rdata0 : rdata;
                er  = sel0 ? err0 : err;
                break;
            end
        end
        req = 1'b0;
        req0 = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 1'b0; we = 1'b0; addr = '0; wdata = '0; f3 = '0;
        req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0; f30 = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", ready); end
        checks++; if (rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata got %h want 0", rdata); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (ready0 !== 1'b0 || busy0 !== 1'b0) begin errors++; $display("FAIL reset_lat0 got ready=%b busy=%b want 0 0", ready0, busy0); end
    endtask

    task automatic test_word();
        logic [31:0] rd; logic er; int lat, bn;
        txn(1'b0, 1'b1, B, 32'hDEADBEEF, 3'b010, rd, er, lat, bn);
        checks++; if (lat !== 3) begin errors++; $display("FAIL sw_latency got %0d want 3", lat); end
        checks++; if (er !== 1'b0 || rd !== 32'd0) begin errors++; $display("FAIL sw_resp got err=%b rdata=%h want 0 00000000", er, rd); end
        checks++; if (bn !== 3) begin errors++; $display("FAIL sw_busy_cycles got %0d want 3", bn); end
        txn(1'b0, 1'b0, B, 32'd0, 3'b010, rd, er, lat, bn);
        checks++; if (lat !== 3) begin errors++; $display("FAIL lw_latency got %0d want 3", lat); end
        checks++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin errors++; $display("FAIL lw_data got %h err=%b want deadbeef 0", rd, er); end
    endtask

    task automatic test_loads();
        logic [31:0] offs [7] = '{3, 3, 0, 2, 0, 1, 2};
        logic [2:0]  fs   [7] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000, 3'b100, 3'b001};
        logic [31:0] exp  [7] = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFBEEF, 32'h0000DEAD,
                                  32'hFFFFFFEF, 32'h000000BE, 32'hFFFFDEAD};
        logic [31:0] rd; logic er; int lat, bn;
        for (int i = 0; i < 7; i++) begin
            txn(1'b0, 1'b0, B + offs[i], 32'd0, fs[i], rd, er, lat, bn);
            checks++;
            if (rd !== exp[i] || er !== 1'b0 || lat !== 3) begin
                errors++;
                $display("FAIL load_%0d got %h err=%b lat=%0d want %h 0 3", i, rd, er, lat, exp[i]);
            end
        end
    endtask

    task automatic test_partial();
        logic [31:0] rd; logic er; int lat, bn;
        txn(1'b0, 1'b1, B + 1, 32'hAAAAAA11, 3'b000, rd, er, lat, bn);
        checks++; if (er !== 1'b0 || lat !== 3) begin errors++; $display("FAIL sb_resp got err=%b lat=%0d want 0 3", er, lat); end
        txn(1'b0, 1'b1, B + 2, 32'h55552233, 3'b001, rd, er, lat, bn);
        checks++; if (er !== 1'b0 || lat !== 3) begin errors++; $display("FAIL sh_resp got err=%b lat=%0d want 0 3", er, lat); end
        txn(1'b0, 1'b0, B, 32'd0, 3'b010, rd, er, lat, bn);
        checks++; if (rd !== 32'h223311EF) begin errors++; $display("FAIL partial_word got %h want 223311ef", rd); end
        txn(1'b0, 1'b1, B + 32'hFFC, 32'h0BADF00D, 3'b010, rd, er, lat, bn);
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL top_word_store got err=%b want 0", er); end
        txn(1'b0, 1'b0, B + 32'hFFC, 32'd0, 3'b010, rd, er, lat, bn);
        checks++; if (rd !== 32'h0BADF00D || er !== 1'b0) begin errors++; $display("FAIL top_word_load got %h err=%b want 0badf00d 0", rd, er); end
    endtask

    task automatic test_errors();
        logic        ws   [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [31:0] as   [7] = '{B + 2, B + 32'h1000, 32'h1000FFFC, B + 1, B, B, B + 1};
        logic [2:0]  fs   [7] = '{3'b010, 3'b010, 3'b010, 3'b001, 3'b011, 3'b100, 3'b010};
        logic [31:0] rd; logic er; int lat, bn;
        for (int i = 0; i < 7; i++) begin
            txn(1'b0, ws[i], as[i], 32'hFFFFFFFF, fs[i], rd, er, lat, bn);
            checks++;
            if (er !== 1'b1 || rd !== 32'd0 || lat !== 3) begin
                errors++;
                $display("FAIL err_case_%0d got err=%b rdata=%h lat=%0d want 1 00000000 3", i, er, rd, lat);
            end
        end
        txn(1'b0, 1'b0, B, 32'd0, 3'b010, rd, er, lat, bn);
        checks++; if (rd !== 32'h223311EF) begin errors++; $display("FAIL err_ram_unchanged got %h want 223311ef", rd); end
    endtask

    task automatic test_reset_in_wait();
        logic [31:0] rd; logic er; int lat, bn;
        int pulses;
        txn(1'b0, 1'b1, B + 8, 32'hCAFEF00D, 3'b010, rd, er, lat, bn);
        req = 1'b1; we = 1'b1; addr = B + 8; wdata = 32'h12345678; f3 = 3'b010;
        pulses = 0;
        @(posedge clk); #1;
        if (ready) pulses++;
        @(posedge clk); #1;
        if (ready) pulses++;
        rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_wait_busy got %b want 0", busy); end
        req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (ready) pulses++;
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL rst_wait_ready got %0d pulses want 0", pulses); end
        txn(1'b0, 1'b0, B + 8, 32'd0, 3'b010, rd, er, lat, bn);
        checks++; if (rd !== 32'hCAFEF00D || er !== 1'b0) begin errors++; $display("FAIL rst_wait_no_write got %h want cafef00d", rd); end
    endtask

    task automatic test_latency0();
        logic [31:0] rd; logic er; int lat, bn;
        txn(1'b1, 1'b1, B, 32'h01020304, 3'b010, rd, er, lat, bn);
        checks++; if (lat !== 1 || er !== 1'b0) begin errors++; $display("FAIL lat0_sw got lat=%0d err=%b want 1 0", lat, er); end
        txn(1'b1, 1'b0, B, 32'd0, 3'b010, rd, er, lat, bn);
        checks++; if (lat !== 1 || rd !== 32'h01020304) begin errors++; $display("FAIL lat0_lw got lat=%0d rdata=%h want 1 01020304", lat, rd); end
    endtask

    task automatic test_back_to_back();
        req0 = 1'b1; we0 = 1'b0; addr0 = B + 1; wdata0 = 32'd0; f30 = 3'b100;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            checks++;
            if (ready0 !== ((i % 2) == 0) || busy0 !== ((i % 2) == 0)) begin
                errors++;
                $display("FAIL b2b_cycle_%0d got ready=%b busy=%b want %0d %0d", i, ready0, busy0, (i % 2) == 0, (i % 2) == 0);
            end
            if ((i % 2) == 0) begin
                checks++;
                if (rdata0 !== 32'h00000003) begin errors++; $display("FAIL b2b_data_%0d got %h want 00000003", i, rdata0); end
            end
        end
        req0 = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_word();
        test_loads();
        test_partial();
        test_errors();
        test_reset_in_wait();
        test_latency0();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
